// File: rtl/gnr_cycle_detect_pkg.sv
// Shared types for the GNR cycle detector:
// controller state encoding and default counter width.
package gnr_cycle_detect_pkg;

    localparam int GNR_CNT_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_RESULT  = 3'd4
    } gnr_state_e;

endpackage

// File: rtl/gnr_cycle_detect_if.sv
// Result handshake bundle of the GNR cycle detector:
// valid/ready plus meet step, period and timeout fields.
interface gnr_cycle_detect_if
    import gnr_cycle_detect_pkg::*;
#(
    parameter int CNT_WIDTH = GNR_CNT_WIDTH
);

    logic                 res_valid;
    logic                 res_ready;
    logic [CNT_WIDTH-1:0] meet_steps;
    logic [CNT_WIDTH-1:0] period;
    logic                 timeout;

    modport master (
        output res_valid,
        output meet_steps,
        output period,
        output timeout,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  meet_steps,
        input  period,
        input  timeout,
        output res_ready
    );

endinterface

// File: rtl/gnr_vec_cmp.sv
// Combinational full-width equality of the tortoise and hare
// state vectors, shared by the search and measure phases.
module gnr_vec_cmp #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq
);

    assign eq = (a == b);

endmodule

// File: rtl/gnr_cycle_detect.sv
// Floyd tortoise/hare cycle detector steering an external node
// array: finds the meet step, then measures the cycle period.
module gnr_cycle_detect
    import gnr_cycle_detect_pkg::*;
#(
    parameter int NUM_NODES = 16,
    parameter int CNT_WIDTH = GNR_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_NODES-1:0] init_vec,
    input  logic [CNT_WIDTH-1:0] max_steps,
    input  logic [NUM_NODES-1:0] lat_s0,
    input  logic [NUM_NODES-1:0] lat_s1,
    output logic                 reset_nos,
    output logic [NUM_NODES-1:0] init_state,
    output logic                 start_s0,
    output logic                 start_s1,
    output logic                 busy,
    gnr_cycle_detect_if.master   res
);

    localparam logic [CNT_WIDTH:0]   C_ONE   = {{CNT_WIDTH{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH:0]   C_THREE = {{(CNT_WIDTH-1){1'b0}}, 2'b11};
    localparam logic [CNT_WIDTH-1:0] P_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    gnr_state_e           state_q, state_d;
    logic [CNT_WIDTH:0]   c_q, c_d;
    logic [CNT_WIDTH-1:0] p_q, p_d;
    logic [CNT_WIDTH-1:0] max_q, max_d;
    logic [NUM_NODES-1:0] init_q, init_d;
    logic [CNT_WIDTH-1:0] meet_q, meet_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic                 tout_q, tout_d;
    logic [CNT_WIDTH-1:0] k;
    logic                 cmp_cyc;
    logic                 eq;

    gnr_vec_cmp #(.W(NUM_NODES)) u_cmp (
        .a  (lat_s0),
        .b  (lat_s1),
        .eq (eq)
    );

    // Odd c >= 3: hare has taken 2k steps, tortoise k steps.
    assign k       = c_q[CNT_WIDTH:1];
    assign cmp_cyc = c_q[0] && (c_q >= C_THREE);

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        p_d       = p_q;
        max_d     = max_q;
        init_d    = init_q;
        meet_d    = meet_q;
        period_d  = period_q;
        tout_d    = tout_q;
        reset_nos = 1'b0;
        start_s0  = 1'b0;
        start_s1  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    init_d   = init_vec;
                    max_d    = max_steps;
                    meet_d   = '0;
                    period_d = '0;
                    tout_d   = 1'b0;
                    c_d      = '0;
                    p_d      = '0;
                    state_d  = ST_INIT;
                end
            end
            ST_INIT: begin
                reset_nos = 1'b1;
                if (max_q == '0) begin
                    tout_d  = 1'b1;
                    state_d = ST_RESULT;
                end else begin
                    c_d     = C_ONE;
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                start_s0 = 1'b1;
                start_s1 = 1'b1;
                c_d      = c_q + C_ONE;
                if (cmp_cyc) begin
                    if (eq) begin
                        meet_d   = k;
                        p_d      = '0;
                        start_s0 = 1'b0;
                        start_s1 = 1'b0;
                        state_d  = ST_MEASURE;
                    end else if (k == max_q) begin
                        tout_d   = 1'b1;
                        meet_d   = k;
                        period_d = '0;
                        start_s0 = 1'b0;
                        start_s1 = 1'b0;
                        state_d  = ST_RESULT;
                    end
                end
            end
            ST_MEASURE: begin
                start_s1 = 1'b1;
                p_d      = p_q + P_ONE;
                if (p_q != '0) begin
                    if (eq) begin
                        period_d = p_q;
                        start_s1 = 1'b0;
                        state_d  = ST_RESULT;
                    end else if (p_q == max_q) begin
                        tout_d   = 1'b1;
                        period_d = '0;
                        state_d  = ST_RESULT;
                    end
                end
            end
            ST_RESULT: begin
                if (res.res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            c_q      <= '0;
            p_q      <= '0;
            max_q    <= '0;
            init_q   <= '0;
            meet_q   <= '0;
            period_q <= '0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            p_q      <= p_d;
            max_q    <= max_d;
            init_q   <= init_d;
            meet_q   <= meet_d;
            period_q <= period_d;
            tout_q   <= tout_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign init_state     = init_q;
    assign res.res_valid  = (state_q == ST_RESULT);
    assign res.meet_steps = meet_q;
    assign res.period     = period_q;
    assign res.timeout    = tout_q;

endmodule

// File: tb/tb_gnr_cycle_detect.sv
// Scoreboard bench for gnr_cycle_detect with a 4-node array model
// (fixed point, inverter oscillator, one-hot rotator).
module tb_gnr_cycle_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  init_vec = '0;
    logic [31:0] max_steps = '0;
    logic [3:0]  lat_s0, lat_s1, init_state;
    logic        reset_nos, start_s0, start_s1, busy;

    gnr_cycle_detect_if #(.CNT_WIDTH(32)) rif();

    gnr_cycle_detect #(.NUM_NODES(4), .CNT_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .init_vec   (init_vec),
        .max_steps  (max_steps),
        .lat_s0     (lat_s0),
        .lat_s1     (lat_s1),
        .reset_nos  (reset_nos),
        .init_state (init_state),
        .start_s0   (start_s0),
        .start_s1   (start_s1),
        .busy       (busy),
        .res        (rif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] meet;
        logic [31:0] per;
        logic        tout;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mode  = 0;
    bit   vseen = 1'b0;

    // Node array model: hare steps per start_s1, tortoise every 2nd start_s0.
    logic [3:0] s0 = '0;
    logic [3:0] s1 = '0;
    logic       par = 1'b0;

    function automatic logic [3:0] nxt(input logic [3:0] v);
        case (mode)
            0:       return v;
            1:       return ~v;
            default: return {v[2:0], v[3]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset_nos) begin
            s0  <= init_state;
            s1  <= init_state;
            par <= 1'b0;
        end else begin
            if (start_s1) s1 <= nxt(s1);
            if (start_s0) begin
                par <= ~par;
                if (par) s0 <= nxt(s0);
            end
        end
    end

    assign lat_s0 = s0;
    assign lat_s1 = s1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: one scoreboard pop per result presentation.
    always @(negedge clk) begin
        if (rif.res_valid && !vseen) begin
            exp_t e;
            vseen = 1'b1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: result with no expectation");
            end else begin
                e = sb.pop_front();
                chk("meet_steps", rif.meet_steps, e.meet);
                chk("period", rif.period, e.per);
                chk("timeout", {31'b0, rif.timeout}, {31'b0, e.tout});
            end
        end else if (!rif.res_valid) begin
            vseen = 1'b0;
        end
    end

    task automatic run(input logic [3:0] iv, input logic [31:0] ms,
                       input int md, input logic [31:0] em,
                       input logic [31:0] ep, input logic et,
                       input int hold, input bit glitch);
        bit got;
        mode = md;
        sb.push_back(exp_t'{meet: em, per: ep, tout: et});
        init_vec  = iv;
        max_steps = ms;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rif.res_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            if (glitch && i == 1) begin
                start     = 1'b1;
                init_vec  = ~iv;
                max_steps = 32'd0;
            end
            if (glitch && i == 2) begin
                start = 1'b0;
                chk("init_state_kept", {28'b0, init_state}, {28'b0, iv});
            end
        end
        if (!got && !rif.res_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL res_valid_timeout: got 0 expected 1");
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, rif.res_valid}, 32'd1);
            chk("hold_meet", rif.meet_steps, em);
            chk("hold_period", rif.period, ep);
            chk("hold_timeout", {31'b0, rif.timeout}, {31'b0, et});
        end
        rif.res_ready = 1'b1;
        @(negedge clk);
        rif.res_ready = 1'b0;
        chk("valid_drop", {31'b0, rif.res_valid}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_valid"}, {31'b0, rif.res_valid}, 32'd0);
        chk({tag, "_timeout"}, {31'b0, rif.timeout}, 32'd0);
        chk({tag, "_reset_nos"}, {31'b0, reset_nos}, 32'd0);
        chk({tag, "_start_s0"}, {31'b0, start_s0}, 32'd0);
        chk({tag, "_start_s1"}, {31'b0, start_s1}, 32'd0);
        chk({tag, "_meet"}, rif.meet_steps, 32'd0);
        chk({tag, "_period"}, rif.period, 32'd0);
        chk({tag, "_init_state"}, {28'b0, init_state}, 32'd0);
    endtask

    initial begin
        rif.res_ready = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst = 1'b0;
        run(4'b1010, 32'd8, 0, 32'd1, 32'd1, 1'b0, 0, 1'b0);
        run(4'b0011, 32'd8, 1, 32'd2, 32'd2, 1'b0, 5, 1'b0);
        run(4'b0011, 32'd1, 1, 32'd1, 32'd0, 1'b1, 0, 1'b0);
        run(4'b0011, 32'd0, 1, 32'd0, 32'd0, 1'b1, 0, 1'b0);
        run(4'b0001, 32'd8, 2, 32'd4, 32'd4, 1'b0, 0, 1'b0);
        run(4'b0011, 32'd8, 1, 32'd2, 32'd2, 1'b0, 0, 1'b1);
        mode      = 0;
        init_vec  = 4'b0110;
        max_steps = 32'd8;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("search_start_s1", {31'b0, start_s1}, 32'd1);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        run(4'b1010, 32'd8, 0, 32'd1, 32'd1, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gnr_cycle_detect.md
GNR_CYCLE_DETECT -- requirements
Module: gnr_cycle_detect

Interface
REQ-001 SHALL have parameter NUM_NODES, default 16: number of network nodes observed.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of step and period counters.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  begin a run; sampled only in IDLE.
REQ-006 SHALL have port init_vec  in  NUM_NODES  initial network state; captured on accepted start.
REQ-007 SHALL have port max_steps  in  CNT_WIDTH  step bound; captured on accepted start.
REQ-008 SHALL have port lat_s0  in  NUM_NODES  tortoise state vector from the node array.
REQ-009 SHALL have port lat_s1  in  NUM_NODES  hare state vector from the node array.
REQ-010 SHALL have port reset_nos  out  1  load init_state into all nodes.
REQ-011 SHALL have port init_state  out  NUM_NODES  per-node init value (captured init_vec).
REQ-012 SHALL have port start_s0  out  1  advance tortoise (nodes step it every second assertion).
REQ-013 SHALL have port start_s1  out  1  advance hare (one step per assertion).
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have ports res_valid out 1 and res_ready in 1: result handshake.
REQ-016 SHALL have ports meet_steps out CNT_WIDTH, period out CNT_WIDTH, timeout out 1: result fields.

Function
REQ-017 SHALL implement FSM IDLE -> INIT -> SEARCH -> MEASURE -> RESULT -> IDLE.
REQ-018 SHALL, in IDLE with start=1, capture init_vec and max_steps and go to INIT; start in any other state is ignored.
REQ-019 SHALL, in INIT (exactly one cycle), assert reset_nos=1 with start_s0=start_s1=0, then go to SEARCH with cycle counter c=1; if captured max_steps=0, go directly to RESULT with timeout=1, meet_steps=0, period=0.
REQ-020 SHALL, in SEARCH, drive start_s0=start_s1=1 each cycle except a cycle in which a match or timeout is declared (both 0 that cycle); c increments each SEARCH cycle.
REQ-021 SHALL compare only in SEARCH cycles with c odd and c>=3 (hare 2k steps, tortoise k steps, k=(c-1)/2); match means lat_s0==lat_s1 on all bits.
REQ-022 SHALL on match set meet_steps=k and go to MEASURE with period counter p=0.
REQ-023 SHALL on a compare-cycle mismatch with k==max_steps set timeout=1, meet_steps=k, period=0 and go to RESULT.
REQ-024 SHALL, in MEASURE, drive start_s0=0, start_s1=1; p increments each cycle; in cycles with p>=1 compare lat_s1==lat_s0; on match set period=p, drive start_s1=0 that cycle, go to RESULT.
REQ-025 SHALL in MEASURE, if p reaches max_steps without match, set timeout=1, period=0, go to RESULT.
REQ-026 SHALL in RESULT hold res_valid=1 and stable meet_steps/period/timeout until res_ready=1, then go to IDLE; res_valid falls the following cycle.
REQ-027 SHALL keep reset_nos, start_s0, start_s1 at 0 in IDLE and RESULT.
REQ-028 SHALL hold result fields stable in IDLE until the next accepted start.

Reset
REQ-029 SHALL on rst=1, at any time including mid-run, force IDLE and set busy, res_valid, timeout, reset_nos, start_s0, start_s1 to 0 and meet_steps, period, init_state and counters to 0.
REQ-030 SHALL accept a new start in the first cycle after rst deasserts.

Structure
REQ-031 SHALL place the FSM state encoding and CNT_WIDTH default in the shared GNR package.
REQ-032 SHALL use one sub-module, gnr_vec_cmp (NUM_NODES-wide registered-free equality compare), instantiated once, shared by SEARCH and MEASURE.

Verification (NUM_NODES=4, bench models node array)
REQ-033 SHALL verify fixed-point network (next=current), init_vec=4'b1010, max_steps=8 -> match at c=3, meet_steps=1, period=1, timeout=0.
REQ-034 SHALL verify oscillator (next=~current), init_vec=4'b0011, max_steps=8 -> meet_steps=2, period=2, timeout=0.
REQ-035 SHALL verify oscillator with max_steps=1 -> timeout=1, meet_steps=1, period=0; max_steps=0 -> RESULT directly after INIT, timeout=1.
REQ-036 SHALL verify res_ready held low 5 cycles in RESULT -> res_valid and fields stable; IDLE one cycle after res_ready=1.
REQ-037 SHALL verify rst asserted mid-SEARCH -> all outputs 0 immediately; subsequent start completes REQ-033 result correctly.
REQ-038 SHALL verify start pulsed during SEARCH -> ignored, captured init_vec and max_steps unchanged.
